// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: accepts one fill command, clips it to the framebuffer and
// streams one row-major framebuffer write per clock to the VGA write port.
module vga_rect_fill #(
  parameter int unsigned FB_WIDTH    = 80,
  parameter int unsigned FB_HEIGHT   = 60,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned COORD_WIDTH = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_WIDTH-1:0] cmd_x,
  input  logic [COORD_WIDTH-1:0] cmd_y,
  input  logic [COORD_WIDTH-1:0] cmd_w,
  input  logic [COORD_WIDTH-1:0] cmd_h,
  input  logic [2:0]             cmd_color,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [2:0]             wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CW = COORD_WIDTH;
  localparam int unsigned EW = COORD_WIDTH + 1;
  localparam int unsigned AW = ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [EW-1:0] FB_W_E = EW'(FB_WIDTH);
  localparam logic [EW-1:0] FB_H_E = EW'(FB_HEIGHT);
  localparam logic [AW-1:0] FB_W_A = AW'(FB_WIDTH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [EW-1:0] x_end_q, x_end_d, y_end_q, y_end_d;
  logic [AW-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [2:0]    color_q, color_d;
  logic          ready_q, busy_q, wr_en_q, done_q;

  logic [EW-1:0] x_sum, y_sum, col_nxt, row_nxt;
  logic          degenerate;

  // Sums are one bit wider than the fields so x+w never wraps before clipping.
  assign x_sum      = EW'(x_q) + EW'(w_q);
  assign y_sum      = EW'(y_q) + EW'(h_q);
  assign col_nxt    = EW'(col_q) + EW'(1);
  assign row_nxt    = EW'(row_q) + EW'(1);
  assign degenerate = (w_q == '0) || (h_q == '0) ||
                      (EW'(x_q) >= FB_W_E) || (EW'(y_q) >= FB_H_E);

  // Next-state and counter update.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    col_d      = col_q;
    row_d      = row_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x_end_d    = (x_sum > FB_W_E) ? FB_W_E : x_sum;
        y_end_d    = (y_sum > FB_H_E) ? FB_H_E : y_sum;
        col_d      = x_q;
        row_d      = y_q;
        row_base_d = AW'(y_q) * FB_W_A;
        addr_d     = row_base_d + AW'(x_q);
        state_d    = degenerate ? S_DONE : S_FILL;
      end
      S_FILL: begin
        // Incremental addressing: +1 along a row, +FB_WIDTH from the row base on wrap.
        if (col_nxt < x_end_q) begin
          col_d  = col_nxt[CW-1:0];
          addr_d = addr_q + AW'(1);
        end else if (row_nxt < y_end_q) begin
          row_d      = row_nxt[CW-1:0];
          col_d      = x_q;
          row_base_d = row_base_q + FB_W_A;
          addr_d     = row_base_q + FB_W_A + AW'(x_q);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered output decodes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      ready_q    <= (state_d == S_IDLE);
      busy_q     <= (state_d != S_IDLE);
      wr_en_q    <= (state_d == S_FILL);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = addr_q;
  assign wr_data   = color_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: a per-cycle behavioural model built from
// clipped rectangle address lists, plus literal checks on the directed cases.
module tb_vga_rect_fill;

  localparam int FBW = 80;
  localparam int FBH = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid;
  logic [6:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [2:0]  cmd_color;
  logic        cmd_ready, wr_en, busy, done;
  logic [16:0] wr_addr;
  logic [2:0]  wr_data;

  vga_rect_fill dut (
    .clock     (clk),
    .reset     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: acceptance cycle, pixel count, expected address list, colour.
  int m_ready_cyc = 0;
  int m_acc       = -1000;
  int m_p         = 0;
  int m_color     = 0;
  int m_q[$];

  // Observed write/done log for the directed literal checks.
  int wlog[$];
  int wdat[$];
  int wcyc[$];
  int dlog[$];

  bit e_ready, e_wr, e_done;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_accept(input int x, input int y, input int w, input int h, input int c);
    int xe, ye;
    xe = (x + w > FBW) ? FBW : x + w;
    ye = (y + h > FBH) ? FBH : y + h;
    m_q.delete();
    if (!(w == 0 || h == 0 || x >= FBW || y >= FBH))
      for (int r = y; r < ye; r++)
        for (int cc = x; cc < xe; cc++)
          m_q.push_back(r * FBW + cc);
    m_p         = m_q.size();
    m_acc       = cyc;
    m_color     = c;
    m_ready_cyc = cyc + 3 + m_p;
  endtask

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc       = -1000;
      m_p         = 0;
      m_ready_cyc = cyc;
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_done", int'(done), 0);
    end else begin
      e_ready = (cyc >= m_ready_cyc);
      e_wr    = (m_acc >= 0) && (cyc >= m_acc + 2) && (cyc <= m_acc + 1 + m_p);
      e_done  = (m_acc >= 0) && (cyc == m_acc + 2 + m_p);
      chk("cmd_ready", int'(cmd_ready), int'(e_ready));
      chk("busy", int'(busy), int'(!e_ready));
      chk("wr_en", int'(wr_en), int'(e_wr));
      chk("done", int'(done), int'(e_done));
      if (e_wr) begin
        chk("wr_addr", int'(wr_addr), m_q[cyc - m_acc - 2]);
        chk("wr_data", int'(wr_data), m_color);
      end
      if (wr_en) begin
        wlog.push_back(int'(wr_addr));
        wdat.push_back(int'(wr_data));
        wcyc.push_back(cyc);
      end
      if (done) dlog.push_back(cyc);
      if (cmd_valid && e_ready)
        model_accept(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h), int'(cmd_color));
    end
  end

  task automatic clear_logs();
    wlog.delete();
    wdat.delete();
    wcyc.delete();
    dlog.delete();
  endtask

  // Present a command and hold it until the DUT takes it; scramble inputs afterwards.
  task automatic send(input int x, input int y, input int w, input int h, input int c);
    int k = 0;
    cmd_x     = 7'(x);
    cmd_y     = 7'(y);
    cmd_w     = 7'(w);
    cmd_h     = 7'(h);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && k < 10000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 10000) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_x     = 7'($urandom);
    cmd_y     = 7'($urandom);
    cmd_w     = 7'($urandom);
    cmd_h     = 7'($urandom);
    cmd_color = 3'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc < m_ready_cyc && k < 10000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 10000) chk("idle_timeout", 0, 1);
  endtask

  function automatic int qat(input int idx);
    return (idx < wlog.size()) ? wlog[idx] : -1;
  endfunction

  function automatic int dfirst();
    return (dlog.size() > 0) ? dlog[0] : -1000;
  endfunction

  initial begin
    int exp_clip[4];
    int bad, a_acc, b_acc, a_done;
    exp_clip = '{4718, 4719, 4798, 4799};
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("idle_addr", int'(wr_addr), 0);
      chk("idle_wr_en", int'(wr_en), 0);
    end

    // Single pixel
    @(posedge clk); #1;
    clear_logs();
    send(3, 2, 1, 1, 5);
    wait_idle();
    chk("px_count", wlog.size(), 1);
    chk("px_addr", qat(0), 163);
    chk("px_data", (wdat.size() > 0) ? wdat[0] : -1, 5);
    chk("px_first_lat", (wcyc.size() > 0) ? wcyc[0] - m_acc : -1, 2);
    chk("px_done_lat", dfirst() - m_acc, 3);

    // Clipped at the bottom-right corner
    clear_logs();
    send(78, 58, 4, 4, 2);
    wait_idle();
    chk("clip_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("clip_addr", qat(i), exp_clip[i]);
    chk("clip_done_lat", dfirst() - m_acc, 6);

    // Full screen
    clear_logs();
    send(0, 0, 80, 60, 7);
    wait_idle();
    chk("full_count", wlog.size(), 4800);
    chk("full_first", qat(0), 0);
    chk("full_last", qat(4799), 4799);
    bad = 0;
    for (int i = 1; i < wlog.size(); i++) if (wlog[i] != wlog[i-1] + 1) bad++;
    chk("full_mono", bad, 0);
    chk("full_done_lat", dfirst() - m_acc, 4802);

    // Degenerate commands
    clear_logs(); send(10, 10, 0, 3, 1); wait_idle();
    chk("deg_w0_writes", wlog.size(), 0);
    chk("deg_w0_done_lat", dfirst() - m_acc, 2);
    clear_logs(); send(80, 10, 5, 3, 1); wait_idle();
    chk("deg_x80_writes", wlog.size(), 0);
    chk("deg_x80_done_lat", dfirst() - m_acc, 2);
    clear_logs(); send(10, 60, 3, 1, 1); wait_idle();
    chk("deg_y60_writes", wlog.size(), 0);
    chk("deg_y60_done_lat", dfirst() - m_acc, 2);

    // Held command while busy
    clear_logs();
    send(10, 10, 2, 2, 3);
    a_acc = m_acc;
    send(20, 5, 3, 2, 1);
    b_acc = m_acc;
    a_done = dfirst();
    wait_idle();
    chk("bp_a_done_lat", a_done - a_acc, 6);
    chk("bp_b_after_done", b_acc - a_done, 1);
    chk("bp_total_writes", wlog.size(), 10);
    bad = 0;
    for (int i = 4; i < wdat.size(); i++) if (wdat[i] != 1) bad++;
    chk("bp_b_color", bad, 0);

    // Reset in the middle of a fill
    send(5, 5, 10, 10, 4);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_wr_en", int'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en_drop", int'(wr_en), 0);
    chk("rst_busy_drop", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (120) @(posedge clk);
    #1;
    chk("rst_no_done", dlog.size(), 0);
    chk("rst_no_writes", wlog.size(), 0);

    // Random commands, sometimes held back-to-back
    for (int n = 0; n < 40; n++) begin
      send($urandom_range(0, 85), $urandom_range(0, 65), $urandom_range(0, 24),
           $urandom_range(0, 24), $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Rectangle fill engine that sits directly upstream of the VGA framebuffer stage. It accepts one fill command at a time (origin, size, colour) over a valid/ready handshake. It clips the rectangle to the scaled framebuffer (80x60 at scaling factor 8) and emits one framebuffer write per clock in row-major order on `wr_en`/`wr_addr`/`wr_data`, which connect straight to the VGA block's write port. Single-pixel plots are commands with w=h=1.

## Interface
- `FB_WIDTH`, default 80: framebuffer columns (640 / PIXEL_SCALING_FACTOR).
- `FB_HEIGHT`, default 60: framebuffer rows (480 / PIXEL_SCALING_FACTOR).
- `ADDR_WIDTH`, default 17: write address width; matches the VGA write port.
- `COORD_WIDTH`, default 7: width of each coordinate/size field; must hold FB_WIDTH and FB_HEIGHT.

- `clock`  in  1  system clock; same clock as the VGA block's `clock` input.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine idle, can accept a command.
- `cmd_x`  in  COORD_WIDTH  left column.
- `cmd_y`  in  COORD_WIDTH  top row.
- `cmd_w`  in  COORD_WIDTH  width in pixels.
- `cmd_h`  in  COORD_WIDTH  height in pixels.
- `cmd_color`  in  3  RGB colour.
- `wr_en`  out  1  framebuffer write strobe.
- `wr_addr`  out  ADDR_WIDTH  framebuffer address, row*FB_WIDTH+col.
- `wr_data`  out  3  colour to write.
- `busy`  out  1  command in progress (state != IDLE).
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch x, y, w, h, colour and go to SETUP.
  - Inputs are ignored after acceptance.
- SETUP (one cycle):
  - Compute `x_end`=min(x+w, FB_WIDTH) and `y_end`=min(y+h, FB_HEIGHT) in COORD_WIDTH+1 bits, so the sum cannot overflow.
  - Degenerate command: w==0, h==0, x>=FB_WIDTH, or y>=FB_HEIGHT. Go to DONE with no writes.
  - Otherwise init col=x, row=y, row_base=y*FB_WIDTH, addr=row_base+x. Go to FILL.
- FILL:
  - `wr_en`=1 every cycle; `wr_addr`=addr; `wr_data`=latched colour.
  - Each cycle advance: col+1 and addr+1 while col+1<x_end.
  - At row end: row+1, col=x, row_base+=FB_WIDTH, addr=row_base+FB_WIDTH+x.
  - After the write at (x_end-1, y_end-1), go to DONE.
  - Addresses are generated incrementally; no multiplier is used in FILL.
- DONE (one cycle): `done`=1, then IDLE.
- All outputs decode from registered state and counters only. There is no combinational path from `cmd_*` to any output except none (`cmd_ready` derives from state only).
- Reset values: state IDLE, `cmd_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- Reset asserted mid-FILL: writes stop immediately (asynchronously) and the command is discarded. No `done` is issued.

## Timing
- Acceptance at edge N (cycle N has `cmd_valid`&&`cmd_ready`).
  - SETUP occupies cycle N+1.
  - First `wr_en` occurs in cycle N+2.
- P = clipped_w*clipped_h writes occupy cycles N+2..N+1+P, one per cycle, contiguous, with no bubbles.
- `done` is high in cycle N+2+P; `cmd_ready` returns in cycle N+3+P.
- Degenerate command: `done` is high in cycle N+2; no `wr_en`.
- Back-to-back commands: minimum spacing is P+3 cycles between acceptances.
- `cmd_valid` held while busy is not accepted; the command stays pending until IDLE.
- The downstream write port has no backpressure; the engine never stalls in FILL.

## Test plan
- Reset, then idle 10 cycles with `cmd_valid`=0:
  - `cmd_ready`=1, `busy`=0, `wr_en`=0, `wr_addr`=0, `done`=0 throughout.
- Command x=3, y=2, w=1, h=1, colour=5:
  - Exactly one write, addr 163, data 5, in cycle N+2.
  - `done` in N+3.
- Command x=78, y=58, w=4, h=4, colour=2 (clipped):
  - Writes to addrs 4718, 4719, 4798, 4799 in that order, data 2.
  - `done` in N+6.
- Command x=0, y=0, w=80, h=60, colour=7:
  - 4800 consecutive writes, addr 0..4799 monotonically.
  - `done` in N+4802.
- Degenerate commands (w=0), then (x=80, w=5), then (y=60, h=1):
  - Zero writes for each; `done` 2 cycles after each acceptance.
- Backpressure and mid-fill reset:
  - Issue 2x2 command A, then hold `cmd_valid` with B (colour 1) during A's fill. B must not be accepted until the cycle after A's `done`, and B's writes must carry colour 1.
  - Assert `reset` during a 10x10 fill: `wr_en` drops at once, and no `done` follows.
